// File: rtl/muldiv_hilo.sv
// muldiv_hilo: HI/LO register file with a single-cycle multiplier and a
// 32-iteration restoring divider for the MIPS execute stage.
module muldiv_hilo (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic [7:0]  alucontrol,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        stall,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // Operation codes shared with the decode stage.
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  // Architectural and divider state
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] quot_q, quot_d;     // dividend shifts out MSB-first, quotient bits shift in
  logic [31:0] rem_q, rem_d;       // partial remainder
  logic [31:0] dvsr_q, dvsr_d;     // divisor magnitude
  logic [31:0] raw_a_q, raw_a_d;   // unmodified dividend, returned as HI on divide-by-zero
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dzero_q, dzero_d;

  // Decode and datapath helpers
  logic        accept;
  logic        is_div;
  logic        div_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        trial_ge;
  logic [31:0] rem_step;
  logic [31:0] quot_fin;
  logic [31:0] rem_fin;

  // Operation decode and operand conditioning for the accepting cycle
  always_comb begin
    accept     = (state_q == IDLE) && en && !flush;
    is_div     = (alucontrol == EXE_DIV_OP) || (alucontrol == EXE_DIVU_OP);
    div_signed = (alucontrol == EXE_DIV_OP);
    a_mag      = (div_signed && srca[31]) ? (32'd0 - srca) : srca;
    b_mag      = (div_signed && srcb[31]) ? (32'd0 - srcb) : srcb;
    // Full-width operands make the low 64 bits of the product the exact result.
    prod_s     = {{32{srca[31]}}, srca} * {{32{srcb[31]}}, srcb};
    prod_u     = {32'd0, srca} * {32'd0, srcb};
  end

  // One restoring-division step: shift in the next dividend bit and try to subtract
  always_comb begin
    trial    = {rem_q, quot_q[31]};
    diff     = trial - {1'b0, dvsr_q};
    trial_ge = (trial >= {1'b0, dvsr_q});
    // When the subtraction succeeds the result is below the divisor, so 32 bits hold it.
    rem_step = trial_ge ? diff[31:0] : trial[31:0];
  end

  // Sign fix-up of the unsigned magnitudes: quotient follows the sign rule,
  // remainder follows the dividend. The most-negative case wraps naturally.
  always_comb begin
    quot_fin = q_neg_q ? (32'd0 - quot_q) : quot_q;
    rem_fin  = r_neg_q ? (32'd0 - rem_q)  : rem_q;
  end

  // Next-state logic for the FSM, HI/LO and divider registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    raw_a_d = raw_a_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dzero_d = dzero_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (alucontrol)
            EXE_MULT_OP: begin
              hi_d = prod_s[63:32];
              lo_d = prod_s[31:0];
            end
            EXE_MULTU_OP: begin
              hi_d = prod_u[63:32];
              lo_d = prod_u[31:0];
            end
            EXE_MTHI_OP: hi_d = srca;
            EXE_MTLO_OP: lo_d = srca;
            EXE_DIV_OP, EXE_DIVU_OP: begin
              raw_a_d = srca;
              quot_d  = a_mag;
              rem_d   = 32'd0;
              dvsr_d  = b_mag;
              q_neg_d = div_signed && (srca[31] ^ srcb[31]);
              r_neg_d = div_signed && srca[31];
              dzero_d = (srcb == 32'd0);
              cnt_d   = 6'd0;
              state_d = DIV_BUSY;
            end
            default: ;
          endcase
        end
      end

      DIV_BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          quot_d = {quot_q[30:0], trial_ge};
          rem_d  = rem_step;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = DIV_DONE;
          end
        end
      end

      DIV_DONE: begin
        // A zero divisor bypasses the iterated result with fixed values.
        if (!flush) begin
          lo_d = dzero_q ? 32'hFFFF_FFFF : quot_fin;
          hi_d = dzero_q ? raw_a_q       : rem_fin;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over everything, including flush and a divide in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      quot_q  <= 32'd0;
      rem_q   <= 32'd0;
      dvsr_q  <= 32'd0;
      raw_a_q <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      raw_a_q <= raw_a_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dzero_q <= dzero_d;
    end
  end

  // Pipeline hold: the accepting divide cycle plus every busy cycle
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      stall = (accept && is_div) || (state_q == DIV_BUSY);
    end
  end

  // MFHI/MFLO read port shows register contents only, no same-cycle bypass
  always_comb begin
    hilo_rdata = 32'd0;
    if (!rst) begin
      if (alucontrol == EXE_MFHI_OP) begin
        hilo_rdata = hi_q;
      end else if (alucontrol == EXE_MFLO_OP) begin
        hilo_rdata = lo_q;
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed testbench for muldiv_hilo: multiply, HI/LO moves, divide timing,
// sign and zero-divisor rules, flush and reset behaviour.
module tb_muldiv_hilo;

  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  logic        clk;
  logic        rst;
  logic        en;
  logic        flush;
  logic [7:0]  alucontrol;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        stall;
  logic [31:0] hilo_rdata;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total_checks;
  int passed_checks;
  int ncyc;

  muldiv_hilo dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .stall      (stall),
    .hilo_rdata (hilo_rdata),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  // Issue a divide at the current negedge and follow stall until it drops.
  // Operands are scrambled while stalled. Returns at the DIV_DONE negedge.
  task automatic run_div(input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int n);
    en = 1'b1; alucontrol = op; srca = a; srcb = b;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      srca = $urandom;
      srcb = $urandom;
      #1;
    end
    en = 1'b0;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst = 1'b1; en = 1'b0; flush = 1'b0;
    alucontrol = 8'h00; srca = 32'd0; srcb = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    alucontrol = EXE_MFHI_OP; en = 1'b1;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rdata", hilo_rdata, 32'd0);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdata", hilo_rdata, 32'd0);

    // MULT -2 * 3
    alucontrol = EXE_MULT_OP; srca = 32'hFFFF_FFFE; srcb = 32'd3; en = 1'b1;
    #1;
    check("mult_stall0", {31'd0, stall}, 32'd0);
    @(negedge clk);
    en = 1'b0;
    check("mult_stall1", {31'd0, stall}, 32'd0);
    check("mult_hi", hi_o, 32'hFFFF_FFFF);
    check("mult_lo", lo_o, 32'hFFFF_FFFA);

    // MULTU 0xFFFFFFFE * 3
    alucontrol = EXE_MULTU_OP; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("multu_hi", hi_o, 32'h0000_0002);
    check("multu_lo", lo_o, 32'hFFFF_FFFA);

    // Ignored: valid op with en=0, and an unrelated code with en=1
    alucontrol = EXE_MULT_OP; srca = 32'd5; srcb = 32'd5; en = 1'b0;
    @(negedge clk);
    check("noen_hi", hi_o, 32'h0000_0002);
    alucontrol = 8'h00; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("nop_lo", lo_o, 32'hFFFF_FFFA);

    // MTHI / MFHI / MTLO / MFLO
    alucontrol = EXE_MTHI_OP; srca = 32'h1234_5678; en = 1'b1;
    #1;
    check("mthi_nobypass", hilo_rdata, 32'd0);
    @(negedge clk);
    alucontrol = EXE_MFHI_OP;
    #1;
    check("mfhi_rdata", hilo_rdata, 32'h1234_5678);
    alucontrol = EXE_MTLO_OP; srca = 32'hA5A5_A5A5;
    @(negedge clk);
    en = 1'b0;
    check("mtlo_hi", hi_o, 32'h1234_5678);
    check("mtlo_lo", lo_o, 32'hA5A5_A5A5);
    alucontrol = EXE_MFLO_OP;
    #1;
    check("mflo_rdata", hilo_rdata, 32'hA5A5_A5A5);
    alucontrol = EXE_MULT_OP;
    #1;
    check("rdata_other", hilo_rdata, 32'd0);

    // Flush in IDLE suppresses acceptance and stall
    alucontrol = EXE_DIV_OP; srca = 32'd9; srcb = 32'd3; en = 1'b1; flush = 1'b1;
    #1;
    check("idleflush_st0", {31'd0, stall}, 32'd0);
    @(negedge clk);
    alucontrol = EXE_MTLO_OP; srca = 32'd0;
    #1;
    check("idleflush_st1", {31'd0, stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0; en = 1'b0;
    check("idleflush_lo", lo_o, 32'hA5A5_A5A5);

    // DIV -7 / 2
    run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, ncyc);
    check("div_stallcyc", ncyc, 32'd33);
    check("div_done_hi", hi_o, 32'h1234_5678);
    check("div_done_lo", lo_o, 32'hA5A5_A5A5);
    @(negedge clk);
    check("div_lo", lo_o, 32'hFFFF_FFFD);
    check("div_hi", hi_o, 32'hFFFF_FFFF);
    check("div_idle_st", {31'd0, stall}, 32'd0);

    // DIVU 100 / 0
    run_div(EXE_DIVU_OP, 32'd100, 32'd0, ncyc);
    check("divu0_cyc", ncyc, 32'd33);
    @(negedge clk);
    check("divu0_lo", lo_o, 32'hFFFF_FFFF);
    check("divu0_hi", hi_o, 32'd100);

    // DIV most-negative / -1 wraps
    run_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, ncyc);
    @(negedge clk);
    check("divwrap_lo", lo_o, 32'h8000_0000);
    check("divwrap_hi", hi_o, 32'd0);

    // DIV 7 / -2
    run_div(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, ncyc);
    @(negedge clk);
    check("divneg_lo", lo_o, 32'hFFFF_FFFD);
    check("divneg_hi", hi_o, 32'd1);

    // DIVU 0xFFFFFFFF / 16
    run_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd16, ncyc);
    @(negedge clk);
    check("divu_lo", lo_o, 32'h0FFF_FFFF);
    check("divu_hi", hi_o, 32'h0000_000F);

    // Signed divide by zero keeps the raw dividend
    run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd0, ncyc);
    @(negedge clk);
    check("div0_lo", lo_o, 32'hFFFF_FFFF);
    check("div0_hi", hi_o, 32'hFFFF_FFF9);

    // Flush in busy cycle 10
    alucontrol = EXE_DIV_OP; srca = 32'd100; srcb = 32'd7; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_st_busy", {31'd0, stall}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_st_after", {31'd0, stall}, 32'd0);
    check("flush_hi", hi_o, 32'hFFFF_FFF9);
    check("flush_lo", lo_o, 32'hFFFF_FFFF);
    repeat (40) @(negedge clk);
    check("flush_late_lo", lo_o, 32'hFFFF_FFFF);

    // Reset in busy cycle 5
    alucontrol = EXE_DIV_OP; srca = 32'd100; srcb = 32'd7; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstdiv_hi", hi_o, 32'd0);
    check("rstdiv_lo", lo_o, 32'd0);
    check("rstdiv_stall", {31'd0, stall}, 32'd0);
    alucontrol = EXE_MTHI_OP; srca = 32'hCAFE_F00D; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("rstdiv_idle", hi_o, 32'hCAFE_F00D);
    repeat (40) @(negedge clk);
    check("rstdiv_late_lo", lo_o, 32'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
